// File: rtl/tri_debug_muxn_trig.sv
// Trace-bus debug mux: group select, quarter rotate, per-quarter merge into the trace chain, pattern trigger.
// Latency: one cycle from inputs to trace_data_out / coretrace_ctrls_out.
// Backpressure: none; the output register holds its value while the trigger is in FROZEN.
module tri_debug_muxn_trig #(
  parameter int DBG_WIDTH      = 32,
  parameter int NUM_GROUPS     = 8,
  parameter int GRP_SEL_WIDTH  = 3,
  parameter int POST_CNT_WIDTH = 8
) (
  input  logic                             nclk,
  input  logic                             rst_n,
  input  logic [GRP_SEL_WIDTH-1:0]         grp_sel,
  input  logic [1:0]                       rot_sel,
  input  logic [3:0]                       lane_en,
  input  logic [NUM_GROUPS*DBG_WIDTH-1:0]  dbg_groups,
  input  logic [DBG_WIDTH-1:0]             trace_data_in,
  input  logic [3:0]                       coretrace_ctrls_in,
  input  logic                             trig_arm,
  input  logic [DBG_WIDTH-1:0]             trig_mask,
  input  logic [DBG_WIDTH-1:0]             trig_pattern,
  input  logic [POST_CNT_WIDTH-1:0]        trig_post_cnt,
  output logic [DBG_WIDTH-1:0]             trace_data_out,
  output logic [3:0]                       coretrace_ctrls_out,
  output logic                             trig_armed,
  output logic                             trig_fired
);

  // Quarter width. Bit numbering in the trace domain is big-endian (bit 0 is
  // the MSB); vectors here are declared [N-1:0], so trace bit k maps to
  // physical bit N-1-k. Quarter 0 is the most-significant byte lane and is
  // enabled by lane_en[3], group 0 sits in the top DBG_WIDTH bits of dbg_groups.
  localparam int QW = DBG_WIDTH / 4;
  localparam int HW = DBG_WIDTH / 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_POST   = 2'd2,
    ST_FROZEN = 2'd3
  } state_e;

  state_e                      state_q, state_d;
  logic [POST_CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DBG_WIDTH-1:0]        trace_q;
  logic [3:0]                  ctrls_q;

  logic [DBG_WIDTH-1:0]        sel;
  logic [DBG_WIDTH-1:0]        rot;
  logic [DBG_WIDTH-1:0]        merged;
  logic                        match;

  // Group select: pick group grp_sel out of the flattened bus.
  always_comb begin
    sel = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      if (grp_sel == GRP_SEL_WIDTH'(g)) begin
        sel = dbg_groups[(NUM_GROUPS-1-g)*DBG_WIDTH +: DBG_WIDTH];
      end
    end
  end

  // Quarter rotation: 11 -> left by W/4, 10 -> left by W/2, 01 -> left by 3W/4.
  always_comb begin
    rot = sel;
    unique case (rot_sel)
      2'b11:   rot = {sel[DBG_WIDTH-QW-1:0], sel[DBG_WIDTH-1:DBG_WIDTH-QW]};
      2'b10:   rot = {sel[HW-1:0],           sel[DBG_WIDTH-1:HW]};
      2'b01:   rot = {sel[QW-1:0],           sel[DBG_WIDTH-1:QW]};
      default: rot = sel;
    endcase
  end

  // Per-quarter merge: enabled lanes take the rotated group, others pass upstream data.
  always_comb begin
    merged = trace_data_in;
    for (int q = 0; q < 4; q++) begin
      if (lane_en[3-q]) begin
        merged[DBG_WIDTH-1-q*QW -: QW] = rot[DBG_WIDTH-1-q*QW -: QW];
      end
    end
  end

  // Trigger compare on the merged bus; masked-out bits never block a match.
  assign match = (((merged ^ trig_pattern) & trig_mask) == '0);

  // Trigger state and post-trigger counter registers.
  always_ff @(posedge nclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; dropping trig_arm wins over match and countdown.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!trig_arm) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (match) begin
            if (trig_post_cnt == '0) begin
              state_d = ST_FROZEN;
            end else begin
              // Post count is latched here only; later changes are ignored.
              cnt_d   = trig_post_cnt;
              state_d = ST_POST;
            end
          end
        end
        ST_POST: begin
          // The cycle with cnt_q==1 still loads the output register, so the
          // frozen value is the merged data N cycles after the match.
          cnt_d = cnt_q - POST_CNT_WIDTH'(1);
          if (cnt_q == POST_CNT_WIDTH'(1)) begin
            state_d = ST_FROZEN;
          end
        end
        ST_FROZEN: begin
          state_d = ST_FROZEN;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output register: track the merged bus except while frozen for capture.
  always_ff @(posedge nclk or negedge rst_n) begin
    if (!rst_n) begin
      trace_q <= '0;
      ctrls_q <= '0;
    end else if (state_q != ST_FROZEN) begin
      trace_q <= merged;
      ctrls_q <= coretrace_ctrls_in;
    end
  end

  assign trace_data_out      = trace_q;
  assign coretrace_ctrls_out = ctrls_q;
  assign trig_armed          = (state_q == ST_ARMED) || (state_q == ST_POST);
  assign trig_fired          = (state_q == ST_FROZEN);

endmodule

// File: tb/tb_tri_debug_muxn_trig.sv
// Bench for tri_debug_muxn_trig: directed test-plan steps plus randomized traffic.
// Expected values come from a timestamp-based reference model of the trigger.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_tri_debug_muxn_trig;

  logic         nclk;
  logic         rst_n;
  logic [2:0]   grp_sel;
  logic [1:0]   rot_sel;
  logic [3:0]   lane_en;
  logic [255:0] dbg_groups;
  logic [31:0]  trace_data_in;
  logic [3:0]   coretrace_ctrls_in;
  logic         trig_arm;
  logic [31:0]  trig_mask;
  logic [31:0]  trig_pattern;
  logic [7:0]   trig_post_cnt;
  logic [31:0]  trace_data_out;
  logic [3:0]   coretrace_ctrls_out;
  logic         trig_armed;
  logic         trig_fired;

  tri_debug_muxn_trig dut (
    .nclk               (nclk),
    .rst_n              (rst_n),
    .grp_sel            (grp_sel),
    .rot_sel            (rot_sel),
    .lane_en            (lane_en),
    .dbg_groups         (dbg_groups),
    .trace_data_in      (trace_data_in),
    .coretrace_ctrls_in (coretrace_ctrls_in),
    .trig_arm           (trig_arm),
    .trig_mask          (trig_mask),
    .trig_pattern       (trig_pattern),
    .trig_post_cnt      (trig_post_cnt),
    .trace_data_out     (trace_data_out),
    .coretrace_ctrls_out(coretrace_ctrls_out),
    .trig_armed         (trig_armed),
    .trig_fired         (trig_fired)
  );

  initial nclk = 1'b0;
  always #5 nclk = ~nclk;

  int checks;
  int failures;

  // Reference model state: groups as an array, trigger as cycle timestamps.
  logic [31:0] grp [8];
  int          cyc;
  int          arm_cyc;   // first ARMED cycle of the current session, -1 if none
  int          frz_cyc;   // cycle whose data gets captured, -1 if no hit yet
  logic [31:0] m_out;
  logic [3:0]  m_ctl;
  int          armed_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_grp(input int g, input logic [31:0] v);
    grp[g] = v;
    for (int i = 0; i < 8; i++) dbg_groups[(7-i)*32 +: 32] = grp[i];
  endtask

  function automatic logic [31:0] ref_merged();
    logic [31:0] s;
    logic [31:0] m;
    int          k;
    s = grp[grp_sel];
    case (rot_sel)
      2'b11:   k = 8;
      2'b10:   k = 16;
      2'b01:   k = 24;
      default: k = 0;
    endcase
    if (k != 0) s = (s << k) | (s >> (32 - k));
    m = 32'h0;
    for (int q = 0; q < 4; q++) if (lane_en[3-q]) m |= 32'hFF << (24 - 8*q);
    return (s & m) | (trace_data_in & ~m);
  endfunction

  task automatic model_reset();
    arm_cyc = -1;
    frz_cyc = -1;
    m_out   = 32'h0;
    m_ctl   = 4'h0;
  endtask

  // Advance the model by the cycle that ends at the coming rising edge.
  task automatic model_step();
    logic [31:0] mg;
    bit          frozen_now;
    mg = ref_merged();
    frozen_now = (frz_cyc >= 0) && (cyc > frz_cyc);
    if (!frozen_now) begin
      m_out = mg;
      m_ctl = coretrace_ctrls_in;
    end
    if (!trig_arm) begin
      arm_cyc = -1;
      frz_cyc = -1;
    end else if (arm_cyc < 0) begin
      arm_cyc = cyc + 1;
    end else if (cyc >= arm_cyc && frz_cyc < 0 &&
                 (((mg ^ trig_pattern) & trig_mask) == 32'h0)) begin
      frz_cyc = cyc + int'(trig_post_cnt);
    end
  endtask

  task automatic tick();
    bit e_fired;
    bit e_armed;
    model_step();
    @(posedge nclk);
    cyc++;
    @(negedge nclk);
    e_fired = (frz_cyc >= 0) && (cyc > frz_cyc);
    e_armed = (arm_cyc >= 0) && (cyc >= arm_cyc) && !e_fired;
    if (trig_armed === 1'b1) armed_seen++;
    chk("model_out",   trace_data_out,             m_out);
    chk("model_ctl",   {28'h0, coretrace_ctrls_out}, {28'h0, m_ctl});
    chk("model_armed", {31'h0, trig_armed},          {31'h0, e_armed});
    chk("model_fired", {31'h0, trig_fired},          {31'h0, e_fired});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    armed_seen = 0;
    rst_n = 1'b0;
    grp_sel = 3'd0; rot_sel = 2'b00; lane_en = 4'b0000;
    trace_data_in = 32'h0; coretrace_ctrls_in = 4'h0;
    trig_arm = 1'b0; trig_mask = 32'h0; trig_pattern = 32'h0; trig_post_cnt = 8'd0;
    for (int i = 0; i < 8; i++) set_grp(i, 32'h0);
    model_reset();

    // Reset state.
    #12;
    chk("rst_out",   trace_data_out,              32'h0);
    chk("rst_ctl",   {28'h0, coretrace_ctrls_out}, 32'h0);
    chk("rst_armed", {31'h0, trig_armed},          32'h0);
    chk("rst_fired", {31'h0, trig_fired},          32'h0);
    @(negedge nclk);
    rst_n = 1'b1;

    // Mux and rotate.
    set_grp(5, 32'h11223344);
    grp_sel = 3'd5; rot_sel = 2'b11; lane_en = 4'b1111;
    tick();
    chk("rot11", trace_data_out, 32'h22334411);
    rot_sel = 2'b01;
    tick();
    chk("rot01", trace_data_out, 32'h44112233);
    rot_sel = 2'b10;
    tick();
    chk("rot10", trace_data_out, 32'h33441122);

    // Lane merge and control passthrough.
    trace_data_in = 32'hAAAAAAAA;
    set_grp(0, 32'h12345678);
    grp_sel = 3'd0; rot_sel = 2'b00; lane_en = 4'b0101;
    coretrace_ctrls_in = 4'b1010;
    tick();
    chk("lane_merge", trace_data_out, 32'hAA34AA78);
    chk("ctrl_pass",  {28'h0, coretrace_ctrls_out}, {28'h0, 4'b1010});

    // Random datapath traffic, trigger disarmed.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 8; i++) set_grp(i, $urandom);
      grp_sel = 3'($urandom_range(0, 7));
      rot_sel = 2'($urandom_range(0, 3));
      lane_en = 4'($urandom_range(0, 15));
      trace_data_in = $urandom;
      coretrace_ctrls_in = 4'($urandom_range(0, 15));
      tick();
    end

    // Immediate freeze with post count zero.
    grp_sel = 3'd2; rot_sel = 2'b00; lane_en = 4'b1111;
    set_grp(2, 32'h0);
    trig_mask = 32'hFFFFFFFF; trig_pattern = 32'hDEADBEEF; trig_post_cnt = 8'd0;
    trig_arm = 1'b1;
    tick();
    tick();
    set_grp(2, 32'hDEADBEEF);
    tick();
    chk("imm_out",   trace_data_out,     32'hDEADBEEF);
    chk("imm_fired", {31'h0, trig_fired}, 32'h1);
    for (int n = 0; n < 3; n++) begin
      set_grp(2, $urandom);
      coretrace_ctrls_in = 4'($urandom_range(0, 15));
      tick();
      chk("imm_hold", trace_data_out, 32'hDEADBEEF);
    end

    // Leaving FROZEN: new data visible two cycles after trig_arm drops.
    trig_arm = 1'b0;
    set_grp(2, 32'h01020304);
    tick();
    chk("unfrz_c1", trace_data_out, 32'hDEADBEEF);
    tick();
    chk("unfrz_c2", trace_data_out, 32'h01020304);

    // Post count of 3 on an incrementing group; capture lands on 0x13.
    grp_sel = 3'd3;
    trig_pattern = 32'h10; trig_post_cnt = 8'd3;
    set_grp(3, 32'h0B);
    tick();
    trig_arm = 1'b1;
    armed_seen = 0;
    for (int v = 12; v < 28; v++) begin
      set_grp(3, 32'(v));
      if (v == 18) trig_post_cnt = 8'd7;
      tick();
    end
    chk("post_out",    trace_data_out,     32'h13);
    chk("post_fired",  {31'h0, trig_fired}, 32'h1);
    chk("post_armcnt", 32'(armed_seen),     32'd7);

    // Arm dropped on the match cycle: back to IDLE, no freeze.
    trig_arm = 1'b0; trig_post_cnt = 8'd0;
    tick();
    trig_arm = 1'b1;
    set_grp(3, 32'h55);
    tick();
    tick();
    set_grp(3, 32'h10);
    trig_arm = 1'b0;
    tick();
    chk("prio_fired", {31'h0, trig_fired}, 32'h0);
    chk("prio_armed", {31'h0, trig_armed}, 32'h0);
    set_grp(3, 32'h77);
    tick();
    chk("prio_flow", trace_data_out, 32'h77);

    // Zero mask freezes on the first ARMED cycle's data.
    trig_mask = 32'h0;
    set_grp(3, 32'hA5A50001);
    trig_arm = 1'b1;
    tick();
    set_grp(3, 32'hA5A50002);
    tick();
    set_grp(3, 32'hA5A50003);
    tick();
    chk("mask0_out",   trace_data_out,     32'hA5A50002);
    chk("mask0_fired", {31'h0, trig_fired}, 32'h1);

    // Asynchronous reset while FROZEN.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out",   trace_data_out,              32'h0);
    chk("arst_ctl",   {28'h0, coretrace_ctrls_out}, 32'h0);
    chk("arst_fired", {31'h0, trig_fired},          32'h0);
    chk("arst_armed", {31'h0, trig_armed},          32'h0);
    model_reset();
    trig_arm = 1'b0;
    @(negedge nclk);
    rst_n = 1'b1;

    // Randomized trigger traffic with a narrow mask so matches are common.
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 8; i++) set_grp(i, $urandom);
      grp_sel = 3'($urandom_range(0, 7));
      rot_sel = 2'($urandom_range(0, 3));
      lane_en = 4'($urandom_range(0, 15));
      trace_data_in = $urandom;
      coretrace_ctrls_in = 4'($urandom_range(0, 15));
      trig_arm = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 7) == 0) begin
        trig_mask = 32'hF << (4 * $urandom_range(0, 7));
        trig_pattern = $urandom;
      end
      trig_post_cnt = 8'($urandom_range(0, 4));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
